// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake and status bundle for router_pkt_fifo.
// The master side drives requests; the slave side is the FIFO.
interface router_pkt_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LEN_W  = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic              lfd_state;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              pkt_active;
  logic [LEN_W:0]    pkt_remaining;
  logic              overflow;
  logic              pkt_err;

  modport master (
    output wr_en, lfd_state, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, count,
    input  pkt_active, pkt_remaining, overflow, pkt_err
  );

  modport slave (
    input  wr_en, lfd_state, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, count,
    output pkt_active, pkt_remaining, overflow, pkt_err
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet FIFO for the router datapath. Each entry carries a header marker so
// the read side can track how many words of the current packet remain.
module router_pkt_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LEN_LSB  = 2,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned AF_LEVEL = 14
) (
  input logic               clk,
  input logic               rst,
  input logic               soft_rst,
  router_pkt_fifo_if.slave  bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned REM_W = LEN_W + 1;

  logic [DATA_W:0]     mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [REM_W-1:0]    pkt_rem_q;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;
  logic                overflow_q;
  logic                pkt_err_q;

  logic                full;
  logic                empty;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W:0]     rd_entry;
  logic                rd_hdr;
  logic [LEN_W-1:0]    rd_len;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // Acceptance uses pre-edge status, so a full FIFO refuses a write even
  // when a read happens in the same cycle.
  assign wr_acc   = bus.wr_en && !full;
  assign rd_acc   = bus.rd_en && !empty;
  assign rd_entry = mem[rd_ptr_q];
  assign rd_hdr   = rd_entry[DATA_W];
  assign rd_len   = rd_entry[LEN_LSB +: LEN_W];

  // Storage array; contents survive both resets.
  always_ff @(posedge clk) begin
    if (wr_acc && !soft_rst) begin
      mem[wr_ptr_q] <= {bus.lfd_state, bus.din};
    end
  end

  // Pointers, occupancy, read data and packet tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_rem_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else if (soft_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_rem_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      pkt_err_q    <= 1'b0;

      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end

      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= rd_entry[DATA_W-1:0];
        if (rd_hdr) begin
          // Payload length plus the trailing parity word.
          pkt_rem_q <= {1'b0, rd_len} + REM_W'(1);
          pkt_err_q <= (pkt_rem_q != '0);
        end else if (pkt_rem_q != '0) begin
          pkt_rem_q <= pkt_rem_q - REM_W'(1);
        end
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.almost_full   = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.count         = count_q;
  assign bus.pkt_active    = (pkt_rem_q != '0);
  assign bus.pkt_remaining = pkt_rem_q;
  assign bus.overflow      = overflow_q;
  assign bus.pkt_err       = pkt_err_q;
endmodule
